// File: rtl/ippcsge_tx_defer_ctl.sv
// ----------------------------------------------------------------------------
// ippcsge_tx_defer_ctl
//   Transmit access controller for the GE MAC TX path (CSMA/CD).
//   Decides when the TX datapath may start a frame. It handles:
//     - inter-frame-gap deferral, restarted by carrier in half duplex
//     - jam after a collision
//     - truncated binary exponential backoff driven by a free-running LFSR
//     - retry counting
//     - aborting the frame on a late collision or on excessive collisions
//   In full duplex, crs and col are ignored.
//
// Ports
//   clk        TX clock; all logic runs on its rising edge
//   rst_       asynchronous active-low reset
//   half_dplx  1 = CSMA/CD, 0 = full duplex; change only while idle
//   crs, col   carrier sense / collision, already synchronous to clk
//   tx_req     level: frame pending, held until tx_done or tx_abort
//   tx_done    pulse: last byte of the frame has been sent
//   tx_grant   level: datapath may send frame bytes
//   jam        level: datapath drives the jam pattern
//   tx_retry   pulse: attempt collided, frame will be resent
//   tx_abort   pulse: frame dropped (late or excessive collision)
//   late_col   pulse: collision seen at or beyond the slot time
//   retry_cnt  collisions seen on the current frame
// ----------------------------------------------------------------------------
module ippcsge_tx_defer_ctl #(
  parameter int IFG_TIME      = 12,
  parameter int JAM_TIME      = 4,
  parameter int SLOT_TIME     = 64,
  parameter int MAX_RETRY     = 16,
  parameter int BACKOFF_LIMIT = 10
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       half_dplx,
  input  logic       crs,
  input  logic       col,
  input  logic       tx_req,
  input  logic       tx_done,
  output logic       tx_grant,
  output logic       jam,
  output logic       tx_retry,
  output logic       tx_abort,
  output logic       late_col,
  output logic [4:0] retry_cnt
);

  localparam int IFG_W  = $clog2(IFG_TIME + 1);
  localparam int JAM_W  = $clog2(JAM_TIME + 1);
  localparam int SLOT_W = $clog2(SLOT_TIME + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEFER,
    ST_XMIT,
    ST_JAM,
    ST_BACKOFF
  } state_e;

  state_e             state_q,     state_d;
  logic [IFG_W-1:0]   ifg_cnt_q,   ifg_cnt_d;
  logic [SLOT_W-1:0]  slot_cnt_q,  slot_cnt_d;
  logic [JAM_W-1:0]   jam_cnt_q,   jam_cnt_d;
  logic [9:0]         bo_num_q,    bo_num_d;
  logic [4:0]         retry_cnt_q, retry_cnt_d;
  logic               late_q,      late_d;
  logic [9:0]         lfsr_q,      lfsr_d;
  logic               tx_retry_q,  tx_retry_d;
  logic               tx_abort_q,  tx_abort_d;
  logic               late_col_q,  late_col_d;

  logic [4:0] retry_inc;
  logic [4:0] bo_k;
  logic [9:0] bo_mask;

  always_comb begin
    state_d     = state_q;
    ifg_cnt_d   = ifg_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    jam_cnt_d   = jam_cnt_q;
    bo_num_d    = bo_num_q;
    retry_cnt_d = retry_cnt_q;
    late_d      = late_q;
    tx_retry_d  = 1'b0;
    tx_abort_d  = 1'b0;
    late_col_d  = 1'b0;

    // x^10 + x^7 + 1. The LFSR runs every cycle regardless of state.
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    // The backoff exponent is min(new retry count, BACKOFF_LIMIT).
    // When k equals 10, the shift wraps to 0, so the mask becomes all ones.
    retry_inc = retry_cnt_q + 5'd1;
    bo_k      = (retry_inc > 5'(BACKOFF_LIMIT)) ? 5'(BACKOFF_LIMIT) : retry_inc;
    bo_mask   = (10'd1 << bo_k) - 10'd1;

    case (state_q)
      ST_IDLE: begin
        if (tx_req) begin
          state_d   = ST_DEFER;
          ifg_cnt_d = '0;
        end
      end

      ST_DEFER: begin
        if (!tx_req) begin
          state_d = ST_IDLE;
        end else if (half_dplx && crs) begin
          ifg_cnt_d = '0;
        end else if (ifg_cnt_q == IFG_W'(IFG_TIME - 1)) begin
          state_d    = ST_XMIT;
          slot_cnt_d = '0;
        end else begin
          ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
        end
      end

      ST_XMIT: begin
        if (slot_cnt_q < SLOT_W'(SLOT_TIME)) begin
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end
        // A collision takes priority over tx_done in the same cycle.
        if (half_dplx && col) begin
          state_d   = ST_JAM;
          jam_cnt_d = '0;
          if (slot_cnt_q >= SLOT_W'(SLOT_TIME)) begin
            late_d     = 1'b1;
            late_col_d = 1'b1;
          end
        end else if (tx_done) begin
          state_d     = ST_IDLE;
          retry_cnt_d = '0;
          late_d      = 1'b0;
        end
      end

      ST_JAM: begin
        if (jam_cnt_q == JAM_W'(JAM_TIME - 1)) begin
          if (late_q || (retry_cnt_q == 5'(MAX_RETRY - 1))) begin
            state_d     = ST_IDLE;
            tx_abort_d  = 1'b1;
            retry_cnt_d = '0;
            late_d      = 1'b0;
          end else begin
            state_d     = ST_BACKOFF;
            tx_retry_d  = 1'b1;
            retry_cnt_d = retry_inc;
            bo_num_d    = lfsr_q & bo_mask;
            slot_cnt_d  = '0;
          end
        end else begin
          jam_cnt_d = jam_cnt_q + JAM_W'(1);
        end
      end

      ST_BACKOFF: begin
        // slot_cnt counts cycles within a slot; bo_num counts the slots left.
        // A zero draw still costs a single cycle here.
        if (bo_num_q == 10'd0) begin
          state_d   = ST_DEFER;
          ifg_cnt_d = '0;
        end else if (slot_cnt_q == SLOT_W'(SLOT_TIME - 1)) begin
          slot_cnt_d = '0;
          bo_num_d   = bo_num_q - 10'd1;
          if (bo_num_q == 10'd1) begin
            state_d   = ST_DEFER;
            ifg_cnt_d = '0;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      ifg_cnt_q   <= '0;
      slot_cnt_q  <= '0;
      jam_cnt_q   <= '0;
      bo_num_q    <= '0;
      retry_cnt_q <= '0;
      late_q      <= 1'b0;
      lfsr_q      <= 10'h3FF;
      tx_retry_q  <= 1'b0;
      tx_abort_q  <= 1'b0;
      late_col_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ifg_cnt_q   <= ifg_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      jam_cnt_q   <= jam_cnt_d;
      bo_num_q    <= bo_num_d;
      retry_cnt_q <= retry_cnt_d;
      late_q      <= late_d;
      lfsr_q      <= lfsr_d;
      tx_retry_q  <= tx_retry_d;
      tx_abort_q  <= tx_abort_d;
      late_col_q  <= late_col_d;
    end
  end

  assign tx_grant  = (state_q == ST_XMIT);
  assign jam       = (state_q == ST_JAM);
  assign tx_retry  = tx_retry_q;
  assign tx_abort  = tx_abort_q;
  assign late_col  = late_col_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_ippcsge_tx_defer_ctl.sv
// ----------------------------------------------------------------------------
// tb_ippcsge_tx_defer_ctl
//   Bench for ippcsge_tx_defer_ctl.
//   u_dut has the default parameters.
//   u_dut_s uses a short slot time, so that a full 16-collision run with
//   backoff exponents up to 10 stays short.
//   Each retry/abort/late_col pulse the bench expects is queued when the
//   collision is driven, then matched against the DUT pulses as they appear.
// ----------------------------------------------------------------------------
module tb_ippcsge_tx_defer_ctl;

  localparam int IFG    = 12;
  localparam int SLOT   = 64;
  localparam int S_SLOT = 4;

  localparam int EV_RETRY = 256;
  localparam int EV_ABORT = 512;
  localparam int EV_LATE  = 768;

  logic clk = 1'b0;
  logic rst_ = 1'b0;

  logic half = 1'b0, crs = 1'b0, col = 1'b0, req = 1'b0, done = 1'b0;
  logic grant, jam, retry, abort, late;
  logic [4:0] rcnt;

  logic s_half = 1'b1, s_crs = 1'b0, s_col = 1'b0, s_req = 1'b0, s_done = 1'b0;
  logic s_grant, s_jam, s_retry, s_abort, s_late;
  logic [4:0] s_rcnt;

  int n_tests = 0;
  int n_fail  = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  ippcsge_tx_defer_ctl u_dut (
    .clk(clk), .rst_(rst_), .half_dplx(half), .crs(crs), .col(col),
    .tx_req(req), .tx_done(done), .tx_grant(grant), .jam(jam),
    .tx_retry(retry), .tx_abort(abort), .late_col(late), .retry_cnt(rcnt)
  );

  ippcsge_tx_defer_ctl #(.SLOT_TIME(S_SLOT)) u_dut_s (
    .clk(clk), .rst_(rst_), .half_dplx(s_half), .crs(s_crs), .col(s_col),
    .tx_req(s_req), .tx_done(s_done), .tx_grant(s_grant), .jam(s_jam),
    .tx_retry(s_retry), .tx_abort(s_abort), .late_col(s_late), .retry_cnt(s_rcnt)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return grant;
      1:       return jam;
      2:       return s_grant;
      default: return s_jam;
    endcase
  endfunction

  // Returns the number of ticks until the signal reaches lvl, or -1 on timeout.
  task automatic wait_lvl(input int sel, input logic lvl, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sig(sel) !== lvl && n < max);
    if (sig(sel) !== lvl) n = -1;
  endtask

  // Accepts a jam-fall-to-grant delay of 1+IFG for r=0, or r*slot+IFG
  // for 1 <= r <= 2^k-1.
  function automatic int bo_ok(input int n, input int k, input int slot);
    int m;
    if (n == IFG + 1) return 1;
    m = n - IFG;
    if (m <= 0 || (m % slot) != 0) return 0;
    return ((m / slot) <= ((1 << k) - 1)) ? 1 : 0;
  endfunction

  task automatic sb_pop(input int ev);
    int e;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_pulse", ev, 0);
    end else begin
      e = sb_q.pop_front();
      check("sb_event", ev, e);
    end
  endtask

  task automatic sb_mon(input logic l, input logic r, input logic a, input logic [4:0] c);
    if (l) sb_pop(EV_LATE + int'(c));
    if (r) sb_pop(EV_RETRY + int'(c));
    if (a) sb_pop(EV_ABORT + int'(c));
  endtask

  always @(negedge clk) begin
    if (rst_) begin
      sb_mon(late, retry, abort, rcnt);
      sb_mon(s_late, s_retry, s_abort, s_rcnt);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_jam", jam, 0);
    rst_ = 1'b1;
    tick();
    check("rst_rcnt", rcnt, 0);
    check("rst_pulses", {retry, abort, late}, 0);
    check("rst_s_grant", s_grant, 0);

    // 1: full duplex, plain IFG, tx_done
    half = 1'b0;
    req  = 1'b1;
    wait_lvl(0, 1'b1, 40, n);
    check("t1_ifg_latency", n, IFG + 1);
    check("t1_jam_low", jam, 0);
    repeat (5) tick();
    done = 1'b1;
    req  = 1'b0;
    tick();
    done = 1'b0;
    check("t1_grant_fall", grant, 0);
    check("t1_rcnt", rcnt, 0);
    repeat (3) tick();

    // 2: half duplex, carrier during DEFER restarts the gap
    half = 1'b1;
    req  = 1'b1;
    repeat (5) tick();
    crs = 1'b1;
    repeat (5) tick();
    check("t2_no_grant_crs", grant, 0);
    crs = 1'b0;
    wait_lvl(0, 1'b1, 40, n);
    check("t2_restart_latency", n, IFG);
    done = 1'b1;
    req  = 1'b0;
    tick();
    done = 1'b0;
    repeat (3) tick();

    // 3: early collision -> jam, retry, backoff of 0 or 1 slot
    req = 1'b1;
    wait_lvl(0, 1'b1, 40, n);
    check("t3_grant", n, IFG + 1);
    repeat (10) tick();
    col = 1'b1;
    sb_q.push_back(EV_RETRY + 1);
    tick();
    col = 1'b0;
    check("t3_jam_on", jam, 1);
    check("t3_grant_off", grant, 0);
    wait_lvl(1, 1'b0, 20, n);
    check("t3_jam_len", n, 4);
    check("t3_rcnt", rcnt, 1);
    wait_lvl(0, 1'b1, 200, n);
    check("t3_backoff", bo_ok(n, 1, SLOT), 1);
    done = 1'b1;
    req  = 1'b0;
    tick();
    done = 1'b0;
    check("t3_rcnt_clr", rcnt, 0);
    repeat (3) tick();

    // 4: late collision -> late_col, jam, abort, no retry
    req = 1'b1;
    wait_lvl(0, 1'b1, 40, n);
    check("t4_grant", n, IFG + 1);
    repeat (70) tick();
    col = 1'b1;
    sb_q.push_back(EV_LATE + 0);
    sb_q.push_back(EV_ABORT + 0);
    tick();
    col = 1'b0;
    check("t4_jam_on", jam, 1);
    wait_lvl(1, 1'b0, 20, n);
    check("t4_jam_len", n, 4);
    req = 1'b0;
    check("t4_rcnt", rcnt, 0);
    repeat (3) tick();
    check("t4_idle", grant, 0);
    check("t4_sb_drained", sb_q.size(), 0);

    // 5: collision on every attempt (short-slot instance)
    s_req = 1'b1;
    wait_lvl(2, 1'b1, 40, n);
    check("t5_first_grant", n, IFG + 1);
    for (int a = 1; a <= 16; a++) begin
      s_col = 1'b1;
      sb_q.push_back((a < 16) ? (EV_RETRY + a) : EV_ABORT);
      tick();
      s_col = 1'b0;
      check("t5_jam_on", s_jam, 1);
      wait_lvl(3, 1'b0, 20, n);
      check("t5_jam_len", n, 4);
      check("t5_rcnt", s_rcnt, (a < 16) ? a : 0);
      if (a == 16) begin
        s_req = 1'b0;
      end else begin
        wait_lvl(2, 1'b1, 6000, n);
        check("t5_backoff", bo_ok(n, (a > 10) ? 10 : a, S_SLOT), 1);
      end
    end
    repeat (3) tick();
    check("t5_idle", s_grant, 0);
    check("t5_sb_drained", sb_q.size(), 0);

    // 6: asynchronous reset during JAM, then a full-duplex collision
    req = 1'b1;
    wait_lvl(0, 1'b1, 40, n);
    check("t6_grant", n, IFG + 1);
    col = 1'b1;
    tick();
    col = 1'b0;
    check("t6_jam_on", jam, 1);
    tick();
    #2;
    rst_ = 1'b0;
    #1;
    check("t6_jam_async_off", jam, 0);
    check("t6_grant_off", grant, 0);
    req = 1'b0;
    repeat (2) tick();
    rst_ = 1'b1;
    repeat (3) tick();
    check("t6_idle_grant", grant, 0);
    check("t6_idle_jam", jam, 0);
    check("t6_rcnt", rcnt, 0);
    half = 1'b0;
    req  = 1'b1;
    wait_lvl(0, 1'b1, 40, n);
    check("t6_fd_grant", n, IFG + 1);
    col = 1'b1;
    tick();
    col = 1'b0;
    check("t6_fd_col_grant", grant, 1);
    check("t6_fd_col_jam", jam, 0);
    tick();
    check("t6_fd_rcnt", rcnt, 0);
    done = 1'b1;
    req  = 1'b0;
    tick();
    done = 1'b0;
    check("t6_fd_done", grant, 0);
    repeat (3) tick();
    check("sb_final_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
